// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Back-to-back frames are sent with no idle cycle while the FIFO holds words.
module uart_tx_cfg #(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DATA_BITS-1:0]                 data_in,
    input  logic                                 data_valid,
    output logic                                 data_ready,
    output logic                                 tx,
    output logic                                 tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int PULSE_W = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BIT_W   = 4;
    localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic                 push;
    logic                 pop;
    logic                 load;
    logic                 pulse_last;
    logic [DATA_BITS-1:0] head;
    logic                 head_parity;

    assign head        = mem_q[rd_ptr_q];
    assign head_parity = PAR_ODD ? ~(^head) : (^head);
    assign pulse_last  = (pulse_q == PULSE_W'(CLOCKS_PER_PULSE - 1));

    assign data_ready  = (count_q != CNT_W'(FIFO_DEPTH));
    assign push        = data_valid && data_ready;
    assign tx          = tx_q;
    assign tx_busy     = (state_q != S_IDLE);
    assign fifo_count  = count_q;

    // FIFO pointer and occupancy update; a simultaneous push and pop leaves the count alone.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Frame sequencer: next state, bit timing and the registered serial line value.
    always_comb begin
        state_d  = state_q;
        pulse_d  = pulse_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        load     = 1'b0;
        pop      = 1'b0;

        if (state_q != S_IDLE) begin
            pulse_d = pulse_last ? '0 : pulse_q + PULSE_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) load = 1'b1;
            end
            S_START: begin
                if (pulse_last) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            S_DATA: begin
                if (pulse_last) begin
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (PAR_EN) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (pulse_last) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (pulse_last) begin
                    if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (count_q != '0) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Starting a frame captures the whole head word, so later pushes cannot disturb it.
        if (load) begin
            pop      = 1'b1;
            shift_d  = head;
            parity_d = head_parity;
            tx_d     = 1'b0;
            pulse_d  = '0;
            bit_d    = '0;
            state_d  = S_START;
        end
    end

    // State, counters and FIFO bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            pulse_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pulse_q  <= pulse_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; flushing the pointers and count makes its contents unreachable.
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: two configurations, a scoreboard of expected
// words filled at push time and drained by a serial frame receiver.
module tb_uart_tx_cfg;

    localparam int CPP     = 4;
    localparam int A_DBITS = 8;
    localparam int A_PAR   = 2;
    localparam int A_STOP  = 2;
    localparam int B_DBITS = 7;
    localparam int B_PAR   = 1;
    localparam int B_STOP  = 1;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 500;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] data_in_a    = '0;
    logic       data_valid_a = 1'b0;
    logic       data_ready_a;
    logic       tx_a;
    logic       tx_busy_a;
    logic [2:0] fifo_count_a;

    logic [6:0] data_in_b    = '0;
    logic       data_valid_b = 1'b0;
    logic       data_ready_b;
    logic       tx_b;
    logic       tx_busy_b;
    logic [2:0] fifo_count_b;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [8:0] sb_a[$];
    logic [8:0] sb_b[$];

    always #5 clk = ~clk;

    uart_tx_cfg #(
        .CLOCKS_PER_PULSE(CPP), .DATA_BITS(A_DBITS), .PARITY(A_PAR),
        .STOP_BITS(A_STOP), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in_a), .data_valid(data_valid_a),
        .data_ready(data_ready_a), .tx(tx_a), .tx_busy(tx_busy_a), .fifo_count(fifo_count_a)
    );

    uart_tx_cfg #(
        .CLOCKS_PER_PULSE(CPP), .DATA_BITS(B_DBITS), .PARITY(B_PAR),
        .STOP_BITS(B_STOP), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .rst(rst), .data_in(data_in_b), .data_valid(data_valid_b),
        .data_ready(data_ready_b), .tx(tx_b), .tx_busy(tx_busy_b), .fifo_count(fifo_count_b)
    );

    function automatic logic tx_of(input bit which);
        return which ? tx_b : tx_a;
    endfunction

    function automatic logic busy_of(input bit which);
        return which ? tx_busy_b : tx_busy_a;
    endfunction

    task automatic push_a(input logic [7:0] d);
        data_in_a    = d;
        data_valid_a = 1'b1;
        sb_a.push_back({1'b0, d});
        @(negedge clk);
        data_valid_a = 1'b0;
    endtask

    task automatic push_b(input logic [6:0] d);
        data_in_b    = d;
        data_valid_b = 1'b1;
        sb_b.push_back({2'b00, d});
        @(negedge clk);
        data_valid_b = 1'b0;
    endtask

    // Receives one frame sampling every cycle; returns on the last cycle of the final stop bit.
    task automatic rx_frame(input bit which, input bit aligned, output int gap, output logic [11:0] seq);
        int         dbits, pm, sbits, nb, hold_err, busy_err, ones;
        logic [8:0] exp_w, got_w;
        logic       exp_p;
        bit         stop_ok;
        dbits    = which ? B_DBITS : A_DBITS;
        pm       = which ? B_PAR : A_PAR;
        sbits    = which ? B_STOP : A_STOP;
        nb       = 1 + dbits + ((pm != 0) ? 1 : 0) + sbits;
        gap      = 0;
        hold_err = 0;
        busy_err = 0;
        seq      = '0;
        got_w    = '0;
        if (!aligned) @(negedge clk);
        while (tx_of(which) !== 1'b0 && gap < TIMEOUT) begin
            @(negedge clk);
            gap++;
        end
        tests_run++;
        if (tx_of(which) !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_start(dut %0d): tx=%b after %0d cycles, required 0", which, tx_of(which), gap);
            return;
        end
        for (int bi = 0; bi < nb; bi++) begin
            for (int ci = 0; ci < CPP; ci++) begin
                if (bi != 0 || ci != 0) @(negedge clk);
                if (ci == 0) seq[bi] = tx_of(which);
                else if (tx_of(which) !== seq[bi]) hold_err++;
                if (busy_of(which) !== 1'b1) busy_err++;
            end
        end
        for (int i = 0; i < dbits; i++) got_w[i] = seq[1 + i];

        tests_run++;
        if (hold_err != 0) begin
            tests_failed++;
            $display("FAIL rx_bit_hold(dut %0d): %0d unstable samples, required 0", which, hold_err);
        end
        tests_run++;
        if (busy_err != 0) begin
            tests_failed++;
            $display("FAIL rx_busy(dut %0d): %0d cycles with tx_busy low in frame, required 0", which, busy_err);
        end
        stop_ok = 1'b1;
        for (int s = 0; s < sbits; s++) if (seq[nb - sbits + s] !== 1'b1) stop_ok = 1'b0;
        tests_run++;
        if (!stop_ok) begin
            tests_failed++;
            $display("FAIL rx_stop(dut %0d): seq=%b, required all stop bits 1", which, seq);
        end

        tests_run++;
        if ((which && sb_b.size() == 0) || (!which && sb_a.size() == 0)) begin
            tests_failed++;
            $display("FAIL rx_unexpected(dut %0d): got frame 0x%0h, required no frame", which, got_w);
            return;
        end
        if (which) exp_w = sb_b.pop_front();
        else       exp_w = sb_a.pop_front();
        if (got_w !== exp_w) begin
            tests_failed++;
            $display("FAIL rx_data(dut %0d): got 0x%0h, required 0x%0h", which, got_w, exp_w);
        end
        if (pm != 0) begin
            ones  = $countones(exp_w);
            exp_p = (pm == 1) ? ~ones[0] : ones[0];
            tests_run++;
            if (seq[1 + dbits] !== exp_p) begin
                tests_failed++;
                $display("FAIL rx_parity(dut %0d): got %b, required %b for 0x%0h", which, seq[1 + dbits], exp_p, exp_w);
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        data_in_a    = 8'hFF;
        data_valid_a = 1'b1;
        data_in_b    = 7'h55;
        data_valid_b = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({tx_a, tx_busy_a, fifo_count_a, data_ready_a} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_a: tx=%b busy=%b count=%0d ready=%b, required 1 0 0 1",
                     tx_a, tx_busy_a, fifo_count_a, data_ready_a);
        end
        tests_run++;
        if ({tx_b, tx_busy_b, fifo_count_b, data_ready_b} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_b: tx=%b busy=%b count=%0d ready=%b, required 1 0 0 1",
                     tx_b, tx_busy_b, fifo_count_b, data_ready_b);
        end
        data_valid_a = 1'b0;
        data_valid_b = 1'b0;
        rst          = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({tx_a, tx_busy_a, fifo_count_a} !== {1'b1, 1'b0, 3'd0}) begin
            tests_failed++;
            $display("FAIL reset_release: tx=%b busy=%b count=%0d, required 1 0 0", tx_a, tx_busy_a, fifo_count_a);
        end
    endtask

    task automatic test_frame_even();
        logic [11:0] exp_seq;
        logic [11:0] seq;
        int          gap;
        exp_seq = 12'b1101_0100_1010;
        push_a(8'hA5);
        rx_frame(1'b0, 1'b0, gap, seq);
        tests_run++;
        if (gap != 0) begin
            tests_failed++;
            $display("FAIL start_latency: start bit %0d cycles late, required 0", gap);
        end
        tests_run++;
        if (seq !== exp_seq) begin
            tests_failed++;
            $display("FAIL frame_a5_seq: got %b, required %b (bit0 first)", seq, exp_seq);
        end
        @(negedge clk);
        tests_run++;
        if ({tx_a, tx_busy_a} !== 2'b10) begin
            tests_failed++;
            $display("FAIL frame_a5_end: tx=%b busy=%b after 48 cycles, required 1 0", tx_a, tx_busy_a);
        end
    endtask

    task automatic test_parity_odd();
        logic [11:0] seq;
        int          gap;
        push_b(7'h7F);
        rx_frame(1'b1, 1'b0, gap, seq);
        tests_run++;
        if (seq[8] !== 1'b0) begin
            tests_failed++;
            $display("FAIL odd_parity_7f: got %b, required 0", seq[8]);
        end
        push_b(7'h3F);
        rx_frame(1'b1, 1'b0, gap, seq);
        tests_run++;
        if (seq[8] !== 1'b1) begin
            tests_failed++;
            $display("FAIL odd_parity_3f: got %b, required 1", seq[8]);
        end
        @(negedge clk);
        tests_run++;
        if ({tx_b, tx_busy_b} !== 2'b10) begin
            tests_failed++;
            $display("FAIL odd_frame_end: tx=%b busy=%b, required 1 0", tx_b, tx_busy_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  words [3];
        logic [11:0] seq;
        int          gap;
        words = '{8'h3C, 8'h81, 8'hF0};
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    data_in_a    = words[k];
                    data_valid_a = 1'b1;
                    sb_a.push_back({1'b0, words[k]});
                    @(negedge clk);
                end
                data_valid_a = 1'b0;
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    rx_frame(1'b0, 1'b0, gap, seq);
                    if (i > 0) begin
                        tests_run++;
                        if (gap != 0) begin
                            tests_failed++;
                            $display("FAIL b2b_gap: frame %0d after %0d idle cycles, required 0", i, gap);
                        end
                    end
                end
            end
        join
        @(negedge clk);
        tests_run++;
        if ({tx_a, tx_busy_a} !== 2'b10) begin
            tests_failed++;
            $display("FAIL b2b_end: tx=%b busy=%b, required 1 0", tx_a, tx_busy_a);
        end
    endtask

    task automatic test_push_pop_same();
        logic [11:0] seq;
        int          gap;
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    data_in_a    = 8'h11 * (k + 1);
                    data_valid_a = 1'b1;
                    sb_a.push_back({1'b0, 8'h11 * (k + 1)});
                    @(negedge clk);
                end
                data_valid_a = 1'b0;
            end
            rx_frame(1'b0, 1'b0, gap, seq);
        join
        tests_run++;
        if (fifo_count_a !== 3'd2) begin
            tests_failed++;
            $display("FAIL pushpop_before: count=%0d, required 2", fifo_count_a);
        end
        data_in_a    = 8'h44;
        data_valid_a = 1'b1;
        sb_a.push_back({1'b0, 8'h44});
        @(negedge clk);
        data_valid_a = 1'b0;
        tests_run++;
        if ({fifo_count_a, tx_a} !== {3'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL pushpop_after: count=%0d tx=%b, required 2 0", fifo_count_a, tx_a);
        end
        for (int i = 0; i < 3; i++) begin
            rx_frame(1'b0, (i == 0), gap, seq);
            tests_run++;
            if (gap != 0) begin
                tests_failed++;
                $display("FAIL pushpop_gap: frame %0d after %0d idle cycles, required 0", i, gap);
            end
        end
        @(negedge clk);
        tests_run++;
        if (tx_busy_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL pushpop_end: busy=%b, required 0", tx_busy_a);
        end
    endtask

    task automatic test_fifo_full();
        logic [11:0] seq;
        int          gap;
        int          cnt;
        logic        exp_ready;
        cnt = 0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    data_in_a    = 8'h30 + 8'(k);
                    data_valid_a = 1'b1;
                    exp_ready    = (cnt != DEPTH);
                    tests_run++;
                    if (data_ready_a !== exp_ready) begin
                        tests_failed++;
                        $display("FAIL full_ready[%0d]: got %b, required %b", k, data_ready_a, exp_ready);
                    end
                    if (exp_ready) sb_a.push_back({1'b0, 8'h30 + 8'(k)});
                    // Only the very first word is popped during this burst (on the second edge).
                    cnt = cnt + (exp_ready ? 1 : 0) - ((k == 1) ? 1 : 0);
                    @(negedge clk);
                end
                data_valid_a = 1'b0;
                tests_run++;
                if (fifo_count_a !== 3'(cnt)) begin
                    tests_failed++;
                    $display("FAIL full_count: got %0d, required %0d", fifo_count_a, cnt);
                end
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    rx_frame(1'b0, 1'b0, gap, seq);
                    if (i > 0) begin
                        tests_run++;
                        if (gap != 0) begin
                            tests_failed++;
                            $display("FAIL full_gap: frame %0d after %0d idle cycles, required 0", i, gap);
                        end
                    end
                end
            end
        join
        @(negedge clk);
        tests_run++;
        if ({tx_busy_a, fifo_count_a, sb_a.size() == 0} !== {1'b0, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL full_end: busy=%b count=%0d pending=%0d, required 0 0 0",
                     tx_busy_a, fifo_count_a, sb_a.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int violations;
        push_a(8'hC4);
        @(negedge clk);
        tests_run++;
        if (tx_a !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_start: tx=%b, required 0", tx_a);
        end
        data_in_a    = 8'h5A;
        data_valid_a = 1'b1;
        sb_a.push_back({1'b0, 8'h5A});
        @(negedge clk);
        data_in_a    = 8'h69;
        sb_a.push_back({1'b0, 8'h69});
        @(negedge clk);
        data_valid_a = 1'b0;
        tests_run++;
        if (fifo_count_a !== 3'd2) begin
            tests_failed++;
            $display("FAIL rst_mid_queued: count=%0d, required 2", fifo_count_a);
        end
        repeat (11) @(negedge clk);
        tests_run++;
        if (tx_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_bit2: tx=%b, required 1 (data bit 2 of 0xC4)", tx_a);
        end
        rst          = 1'b1;
        data_in_a    = 8'hEE;
        data_valid_a = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({tx_a, tx_busy_a, fifo_count_a, data_ready_a} !== {1'b1, 1'b0, 3'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL rst_mid_after: tx=%b busy=%b count=%0d ready=%b, required 1 0 0 1",
                     tx_a, tx_busy_a, fifo_count_a, data_ready_a);
        end
        rst          = 1'b0;
        data_valid_a = 1'b0;
        sb_a.delete();
        violations = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || tx_busy_a !== 1'b0 || fifo_count_a !== 3'd0) violations++;
        end
        tests_run++;
        if (violations != 0) begin
            tests_failed++;
            $display("FAIL rst_mid_quiet: %0d cycles with activity after reset, required 0", violations);
        end
    endtask

    initial begin
        test_reset();
        test_frame_even();
        test_parity_odd();
        test_back_to_back();
        test_push_pop_same();
        test_fifo_full();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
